// File: rtl/cla_word_sequencer.sv
// Sequences an external 8-bit CLA slice over WORDS byte slices, least-significant first,
// to build a multi-precision add/subtract. The slice carry is registered and chained.
module cla_word_sequencer #(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 op_sub,
    input  logic [8*WORDS-1:0]   a_in,
    input  logic [8*WORDS-1:0]   b_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*WORDS-1:0]   result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic [7:0]           cla_a,
    output logic [7:0]           cla_b,
    output logic                 cla_ci,
    input  logic [7:0]           cla_sum,
    input  logic                 cla_co
);
    localparam int unsigned W    = 8 * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(WORDS - 1);
    localparam logic [CntW-1:0] SettleTop = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [W-1:0]    result_q, result_d;
    logic            co_q, co_d;
    logic            ovf_q, ovf_d;

    // Working sum is kept apart from the published result so outputs hold until the next DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = a_in;
                    b_d     = op_sub ? ~b_in : b_in;
                    carry_d = op_sub;
                    idx_d   = '0;
                    cnt_d   = SettleTop;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sum_d[{idx_q, 3'b000} +: 8] = cla_sum;
                    carry_d = cla_co;
                    if (idx_q == LastIdx) begin
                        state_d  = StDone;
                        result_d = sum_d;
                        co_d     = cla_co;
                        ovf_d    = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = SettleTop;
                    end
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    // Slice operands come straight from registers, so they stay stable across the settle window.
    always_comb begin
        start_ready = (state_q == StIdle);
        res_valid   = (state_q == StDone);
        result      = result_q;
        carry_out   = co_q;
        overflow    = ovf_q;
        cla_a       = '0;
        cla_b       = '0;
        cla_ci      = 1'b0;
        if (state_q == StExec) begin
            cla_a  = a_q[{idx_q, 3'b000} +: 8];
            cla_b  = b_q[{idx_q, 3'b000} +: 8];
            cla_ci = carry_q;
        end
    end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer with a behavioural 8-bit CLA slice attached.
module tb_cla_word_sequencer;
    localparam int WORDS  = 4;
    localparam int SETTLE = 2;
    localparam int W      = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [7:0]   cla_a;
    logic [7:0]   cla_b;
    logic         cla_ci;
    logic [7:0]   cla_sum;
    logic         cla_co;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]     got_r;
    logic             got_c;
    logic             got_v;
    int               got_lat;
    logic [WORDS-1:0] got_ci;
    logic [7:0]       got_b0;

    always #5 clk = ~clk;

    assign {cla_co, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {8'd0, cla_ci};

    cla_word_sequencer #(.WORDS(WORDS), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_sub     (op_sub),
        .a_in       (a_in),
        .b_in       (b_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .cla_a      (cla_a),
        .cla_b      (cla_b),
        .cla_ci     (cla_ci),
        .cla_sum    (cla_sum),
        .cla_co     (cla_co)
    );

    // Reference: plain integer arithmetic; returns {overflow, carry, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        longint unsigned s;
        logic [W-1:0]    r;
        logic            c;
        logic            v;
        if (sub) begin
            s = longint'(a) - longint'(b);
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = longint'(a) + longint'(b);
            c = s[W];
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        r = s[W-1:0];
        return {v, c, r};
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        a_in = a;
        b_in = b;
        op_sub = sub;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        got_b0 = cla_b;
        got_ci = '0;
        got_ci[0] = cla_ci;
    endtask

    task automatic wait_done();
        got_lat = 0;
        while (!res_valid && got_lat < 200) begin
            @(posedge clk);
            #1;
            got_lat++;
            if (!res_valid && (got_lat % SETTLE) == 0 && (got_lat / SETTLE) < WORDS)
                got_ci[got_lat/SETTLE] = cla_ci;
        end
        got_r = result;
        got_c = carry_out;
        got_v = overflow;
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({start_ready, res_valid, result, carry_out, overflow, cla_a, cla_b, cla_ci} !==
            {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b res=%h co=%b ov=%b a=%h b=%h ci=%b, want 1 0 0 0 0 0 0 0",
                     start_ready, res_valid, result, carry_out, overflow, cla_a, cla_b, cla_ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005};
        logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007};
        logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [5] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic         ev [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i], ts[i]);
            if (i == 3) begin
                checks++;
                if ({got_b0, got_ci[0]} !== {8'hFE, 1'b1}) begin
                    errors++;
                    $display("FAIL sub_first_slice: cla_b=%h ci=%b, want fe 1", got_b0, got_ci[0]);
                end
            end
            wait_done();
            checks++;
            if (got_lat !== WORDS * SETTLE) begin
                errors++;
                $display("FAIL latency[%0d]: %0d edges, want %0d", i, got_lat, WORDS * SETTLE);
            end
            if (i == 0) begin
                checks++;
                if (got_ci !== 4'b0010) begin
                    errors++;
                    $display("FAIL carry_chain: ci per slice (msb..lsb)=%b, want 0010", got_ci);
                end
            end
            checks++;
            if ({got_r, got_c, got_v} !== {er[i], ec[i], ev[i]}) begin
                errors++;
                $display("FAIL directed[%0d]: res=%h co=%b ov=%b, want res=%h co=%b ov=%b",
                         i, got_r, got_c, got_v, er[i], ec[i], ev[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W+1:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 4 == 0) b = a ^ 32'h8000_0000;
            exp = model(a, b, s);
            start_op(a, b, s);
            wait_done();
            checks++;
            if ({got_v, got_c, got_r} !== exp) begin
                errors++;
                $display("FAIL random[%0d]: %h %s %h -> res=%h co=%b ov=%b, want res=%h co=%b ov=%b",
                         i, a, s ? "-" : "+", b, got_r, got_c, got_v, exp[W-1:0], exp[W], exp[W+1]);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp;
        logic [W+1:0] exp2;
        exp  = model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        exp2 = model(32'h0101_0101, 32'hFEFE_FEFF, 1'b0);
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            op_sub = 1'b0;
            a_in = $urandom;
            b_in = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if ({start_ready, res_valid, overflow, carry_out, result} !== {1'b0, 1'b1, exp}) begin
                errors++;
                $display("FAIL hold[%0d]: rdy=%b vld=%b res=%h co=%b ov=%b, want 0 1 res=%h co=%b ov=%b",
                         i, start_ready, res_valid, result, carry_out, overflow,
                         exp[W-1:0], exp[W], exp[W+1]);
            end
        end
        start_valid = 1'b0;
        consume();
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: rdy=%b vld=%b, want 1 0", start_ready, res_valid);
        end
        start_op(32'h0101_0101, 32'hFEFE_FEFF, 1'b0);
        wait_done();
        checks++;
        if ({got_v, got_c, got_r} !== exp2) begin
            errors++;
            $display("FAIL next_op: res=%h co=%b ov=%b, want res=%h co=%b ov=%b",
                     got_r, got_c, got_v, exp2[W-1:0], exp2[W], exp2[W+1]);
        end
        consume();
    endtask

    task automatic test_async_reset();
        start_op(32'hAAAA_5555, 32'h0F0F_F0F0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, result, carry_out, overflow, cla_a, cla_b, cla_ci} !==
            {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: rdy=%b vld=%b res=%h co=%b ov=%b a=%h b=%h ci=%b, want 1 0 0 0 0 0 0 0",
                     start_ready, res_valid, result, carry_out, overflow, cla_a, cla_b, cla_ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_done();
        checks++;
        if ({got_r, got_c, got_v} !== {32'h2345_6789, 1'b0, 1'b0} || got_lat !== WORDS * SETTLE) begin
            errors++;
            $display("FAIL post_reset_op: res=%h co=%b ov=%b lat=%0d, want 23456789 0 0 lat=%0d",
                     got_r, got_c, got_v, got_lat, WORDS * SETTLE);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
